mux_scan_n: RTL and testbench
=============================

Name: mux_scan_n

Overview:
- Parametrised N-channel, W-bit-wide successor to the board-level 7-to-1 selector.
- Output and current channel are registered.
- Two modes:
  - Manual: the channel comes from `sel`.
  - Auto-scan: the block steps through enabled channels, dwelling a programmable number of cycles on each.
- Drives LED/HEX display paths and ALU operand selection on the DE2 top level.

Parameters:
- `NUM_CH`, 7: number of input channels (2..16).
- `DATA_W`, 1: bits per channel.
- `SEL_W`, 3: select/channel-index width; must satisfy 2**`SEL_W` >= `NUM_CH`.
- `DWELL`, 4: cycles spent on each channel in scan mode (>= 1).

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mux_in`  in  `NUM_CH`*`DATA_W`  channel data; channel k occupies bits [k*`DATA_W` +: `DATA_W`].
- `sel`  in  `SEL_W`  manual channel select.
- `mode`  in  1  0 = manual, 1 = auto-scan.
- `ch_enable`  in  `NUM_CH`  per-channel enable mask; used in scan mode only.
- `hold`  in  1  freezes channel selection (both modes).
- `out`  out  `DATA_W`  registered selected data.
- `cur_ch`  out  `SEL_W`  registered index of the selected channel.
- `ch_valid`  out  1  1 when `cur_ch` is a legal, usable channel.
- `out_strobe`  out  1  one-cycle pulse when `cur_ch` changes or `ch_valid` rises.

Behaviour:
- Reset (asynchronous, any time, including mid-dwell): `out`=0, `cur_ch`=0, `ch_valid`=0, `out_strobe`=0, dwell counter=0, state=MANUAL.
- Core update every cycle: the next channel `nxt` and next valid `nv` are computed combinationally, then registered:
  - `cur_ch` <= `nxt`
  - `ch_valid` <= `nv`
  - `out` <= (`nv` ? `mux_in` slice[`nxt`] : 0)
  - `out` and `cur_ch` therefore always correspond in the same cycle.
- Latency: a change on `sel` or `mux_in` appears on `out` exactly 1 cycle later.
- State machine: two states, MANUAL and SCAN; the state register follows `mode` each cycle.
- MANUAL:
  - `nxt` = `sel`.
  - If `sel` >= `NUM_CH`: `nv`=0 and `out`=0, matching the legacy default case.
  - `ch_enable` is ignored.
  - `hold`=1: `nxt` = `cur_ch`; `sel` is ignored; `out` keeps tracking live data on the frozen channel.
- SCAN:
  - Dwell counter runs 0..`DWELL`-1.
  - At `DWELL`-1: counter clears and `nxt` = next enabled channel strictly after `cur_ch`, searching upward with wrap from `NUM_CH`-1 to 0.
  - If `cur_ch` is the only enabled channel, `nxt` = `cur_ch` (no strobe).
  - `hold`=1: counter and `cur_ch` frozen; data still tracked.
- Entering SCAN (MANUAL→SCAN edge):
  - Counter cleared.
  - If `cur_ch` is enabled and valid, stay on it; otherwise move to the next enabled channel on the first SCAN cycle.
- Leaving SCAN: the next cycle takes `sel` as in MANUAL; counter cleared.
- Mask change during scan:
  - If the current channel becomes disabled, the block advances to the next enabled channel on the following edge, regardless of the dwell count, and the counter clears.
  - `hold` does not block this forced advance.
- Empty mask in SCAN: `nxt` = `cur_ch`, `nv`=0, `out`=0, counter held at 0. Scanning resumes from the first enabled channel after `cur_ch` once any bit sets.
- `out_strobe`: registered as (`nxt` != `cur_ch`) OR (`nv` & ~`ch_valid`). Never asserted in the reset cycle.
- `DWELL`=1: the channel advances every cycle.

Decomposition:
- Shared package `mux_pkg`:
  - Mode encodings `MODE_MANUAL`=1'b0, `MODE_SCAN`=1'b1.
  - State encoding.
  - A function for the `SEL_W` legality check.
- Sub-module `next_enabled_finder` (combinational rotating priority search):
  - Inputs: `ch_enable`, `start` index.
  - Outputs: next index strictly after `start` with wrap, and a `found` flag.
  - `found` is 0 on an empty mask.

Test Plan:
- Manual select latency, defaults (`NUM_CH`=7, `DATA_W`=1):
  - Stimulus: `mux_in`=7'b1010101, reset released, `mode`=0, `sel`=2.
  - Response: 1 cycle later `cur_ch`=2, `out`=1, `ch_valid`=1, `out_strobe` pulses once.
  - Then `sel`=7: next cycle `out`=0, `ch_valid`=0.
- Scan order and dwell:
  - Stimulus: `mode`=1, `ch_enable`=7'b0100101, `DWELL`=4, starting on `cur_ch`=0.
  - Response: `cur_ch` sequence 0,0,0,0,2,2,2,2,5,5,5,5,0…
  - `out_strobe` high exactly on the first cycle of each new channel.
- Forced advance on mask change:
  - Stimulus: scanning on channel 2 at dwell count 1, clear `ch_enable`[2].
  - Response: next edge `cur_ch`=5 and the counter restarts at 0.
- Hold and empty mask:
  - Stimulus: `hold`=1 for 10 cycles in scan.
  - Response: `cur_ch` unchanged, `out` follows toggling `mux_in` on that channel.
  - Stimulus: `ch_enable`=0.
  - Response: `ch_valid`=0, `out`=0.
- Asynchronous reset mid-scan:
  - Stimulus: assert `reset` between clock edges while `cur_ch`=5.
  - Response: `out`, `cur_ch`, `ch_valid` and `out_strobe` are 0 immediately, without waiting for a clock edge.
  - After release, with `mode`=0 and `sel`=3, `cur_ch`=3 after one edge.
- Wide configuration (`NUM_CH`=16, `DATA_W`=8, `SEL_W`=4):
  - Stimulus: channel k data = k*17, `sel`=15.
  - Response: `out`=8'hFF.
  - In scan with all channels enabled and `DWELL`=1, the channel wraps 15→0 with no skipped index.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared encodings and parameter checks for the scanning channel selector.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  // True when a SEL_W-bit index can address every one of num_ch channels.
  function automatic bit sel_w_ok(input int sel_w, input int num_ch);
    return (num_ch >= 2) && (num_ch <= 16) && ((32'd1 << sel_w) >= num_ch);
  endfunction

endpackage

// File: rtl/next_enabled_finder.sv
// Rotating priority search: first enabled channel strictly after start, wrapping to 0.
module next_enabled_finder
  import mux_pkg::*;
#(
  parameter int NUM_CH = 7,
  parameter int SEL_W  = 3
) (
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [SEL_W-1:0]  start,
  output logic [SEL_W-1:0]  next_idx,
  output logic              found
);

  logic [SEL_W-1:0] idx_hi_s;
  logic [SEL_W-1:0] idx_lo_s;
  logic             hi_found_s;

  // Descending sweep so the lowest qualifying index wins; the low pick covers the wrap.
  always_comb begin
    idx_hi_s   = '0;
    idx_lo_s   = '0;
    hi_found_s = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ch_enable[k]) begin
        idx_lo_s = SEL_W'(k);
        if (SEL_W'(k) > start) begin
          idx_hi_s   = SEL_W'(k);
          hi_found_s = 1'b1;
        end else begin
          hi_found_s = hi_found_s;
        end
      end else begin
        idx_lo_s = idx_lo_s;
      end
    end
  end

  assign next_idx = hi_found_s ? idx_hi_s : idx_lo_s;
  assign found    = |ch_enable;

endmodule

// File: rtl/mux_scan_n.sv
// N-channel selector with manual select or auto-scan over enabled channels;
// data, index, valid and change strobe are all registered together.
module mux_scan_n
  import mux_pkg::*;
#(
  parameter int NUM_CH = 7,
  parameter int DATA_W = 1,
  parameter int SEL_W  = 3,
  parameter int DWELL  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] mux_in,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     mode,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic                     hold,
  output logic [DATA_W-1:0]        out,
  output logic [SEL_W-1:0]         cur_ch,
  output logic                     ch_valid,
  output logic                     out_strobe
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  if (!sel_w_ok(SEL_W, NUM_CH) || (DWELL < 1)) begin : g_bad_params
    $error("mux_scan_n: illegal NUM_CH/SEL_W/DWELL combination");
  end

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [SEL_W-1:0] nxt_s;
  logic             nv_s;
  logic [DATA_W-1:0] data_s;
  logic             cur_en_s;
  logic             nxt_en_s;
  logic             nxt_in_range_s;
  logic [SEL_W-1:0] adv_idx_s;
  logic             adv_found_s;

  next_enabled_finder #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_finder (
    .ch_enable (ch_enable),
    .start     (cur_ch),
    .next_idx  (adv_idx_s),
    .found     (adv_found_s)
  );

  // Is the currently registered channel enabled (implies in range)?
  always_comb begin
    cur_en_s = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_ch == SEL_W'(k)) begin
        cur_en_s = ch_enable[k];
      end else begin
        cur_en_s = cur_en_s;
      end
    end
  end

  // Next-channel selection; a disabled current channel forces an advance even under hold.
  always_comb begin
    nxt_s   = cur_ch;
    cnt_s   = '0;
    state_s = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
    if (mode == MODE_MANUAL) begin
      nxt_s = hold ? cur_ch : sel;
    end else if (state_r == ST_MANUAL) begin
      nxt_s = (cur_en_s || !adv_found_s) ? cur_ch : adv_idx_s;
    end else if (!adv_found_s) begin
      nxt_s = cur_ch;
    end else if (!cur_en_s) begin
      nxt_s = adv_idx_s;
    end else if (hold) begin
      cnt_s = cnt_r;
    end else if (cnt_r == CNT_LAST) begin
      nxt_s = adv_idx_s;
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end
  end

  // Decode the chosen channel: legality, enable bit and its data slice.
  always_comb begin
    nxt_in_range_s = 1'b0;
    nxt_en_s       = 1'b0;
    data_s         = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (nxt_s == SEL_W'(k)) begin
        nxt_in_range_s = 1'b1;
        nxt_en_s       = ch_enable[k];
        data_s         = mux_in[k*DATA_W +: DATA_W];
      end else begin
        data_s = data_s;
      end
    end
    nv_s = (mode == MODE_SCAN) ? nxt_en_s : nxt_in_range_s;
  end

  // Output, index and control state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_MANUAL;
      cnt_r      <= '0;
      cur_ch     <= '0;
      ch_valid   <= 1'b0;
      out        <= '0;
      out_strobe <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      cur_ch     <= nxt_s;
      ch_valid   <= nv_s;
      out        <= nv_s ? data_s : '0;
      out_strobe <= (nxt_s != cur_ch) | (nv_s & ~ch_valid);
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed and randomized checks of mux_scan_n (default and 16x8 configurations)
// against a cycle-level behavioural reference.
module tb_mux_scan_n;

  logic         clock = 1'b0;
  logic         reset;
  logic [6:0]   mux_in_a;
  logic [2:0]   sel_a;
  logic         mode_a;
  logic [6:0]   en_a;
  logic         hold_a;
  logic [0:0]   out_a;
  logic [2:0]   cur_a;
  logic         valid_a;
  logic         strobe_a;
  logic [127:0] mux_in_b;
  logic [3:0]   sel_b;
  logic         mode_b;
  logic [15:0]  en_b;
  logic         hold_b;
  logic [7:0]   out_b;
  logic [3:0]   cur_b;
  logic         valid_b;
  logic         strobe_b;

  int compared;
  int mismatched;

  typedef struct {
    int cur;
    bit valid;
    int cnt;
    bit scan;
    int out;
    bit strobe;
  } mstate_t;

  mstate_t ma;
  mstate_t mb;

  always #5 clock = ~clock;

  mux_scan_n dut_a (
    .clock(clock), .reset(reset), .mux_in(mux_in_a), .sel(sel_a), .mode(mode_a),
    .ch_enable(en_a), .hold(hold_a), .out(out_a), .cur_ch(cur_a),
    .ch_valid(valid_a), .out_strobe(strobe_a)
  );

  mux_scan_n #(.NUM_CH(16), .DATA_W(8), .SEL_W(4), .DWELL(1)) dut_b (
    .clock(clock), .reset(reset), .mux_in(mux_in_b), .sel(sel_b), .mode(mode_b),
    .ch_enable(en_b), .hold(hold_b), .out(out_b), .cur_ch(cur_b),
    .ch_valid(valid_b), .out_strobe(strobe_b)
  );

  // Next enabled channel strictly after cur, wrapping; an out-of-range cur restarts from 0.
  function automatic int next_en(input int cur, input int n, input logic [15:0] en);
    int base;
    int c;
    base = (cur >= n) ? n - 1 : cur;
    for (int i = 1; i <= n; i++) begin
      c = (base + i) % n;
      if (en[c]) return c;
    end
    return cur;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input int n, input int dwell,
                                         input int dw, input logic [127:0] din, input int sel,
                                         input bit mode, input logic [15:0] en, input bit hold);
    mstate_t r;
    int  nxt;
    int  cnt;
    bit  nv;
    bit  any;
    bit  cur_on;
    any    = ((int'(en) & ((1 << n) - 1)) != 0);
    cur_on = (s.cur < n) && en[s.cur];
    cnt    = 0;
    if (!mode) nxt = hold ? s.cur : sel;
    else if (!s.scan) nxt = (cur_on || !any) ? s.cur : next_en(s.cur, n, en);
    else if (!any) nxt = s.cur;
    else if (!cur_on) nxt = next_en(s.cur, n, en);
    else if (hold) begin nxt = s.cur; cnt = s.cnt; end
    else if (s.cnt == dwell - 1) nxt = next_en(s.cur, n, en);
    else begin nxt = s.cur; cnt = s.cnt + 1; end
    nv = mode ? ((nxt < n) && en[nxt]) : (nxt < n);
    r.out = 0;
    if (nv) for (int b = 0; b < dw; b++) r.out = r.out | (int'(din[nxt*dw + b]) << b);
    r.strobe = (nxt != s.cur) || (nv && !s.valid);
    r.cur = nxt;
    r.valid = nv;
    r.cnt = cnt;
    r.scan = mode;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all();
    check("a.cur",    32'(cur_a),    32'(ma.cur));
    check("a.out",    32'(out_a),    32'(ma.out));
    check("a.valid",  32'(valid_a),  32'(ma.valid));
    check("a.strobe", 32'(strobe_a), 32'(ma.strobe));
    check("b.cur",    32'(cur_b),    32'(mb.cur));
    check("b.out",    32'(out_b),    32'(mb.out));
    check("b.valid",  32'(valid_b),  32'(mb.valid));
    check("b.strobe", 32'(strobe_b), 32'(mb.strobe));
  endtask

  task automatic tick();
    ma = model_next(ma, 7, 4, 1, 128'(mux_in_a), int'(sel_a), mode_a, 16'(en_a), hold_a);
    mb = model_next(mb, 16, 1, 8, mux_in_b, int'(sel_b), mode_b, en_b, hold_b);
    @(posedge clock);
    #1;
    cmp_all();
  endtask

  int scan_seq[13] = '{0, 0, 0, 0, 2, 2, 2, 2, 5, 5, 5, 5, 0};
  bit found;

  initial begin
    compared = 0;
    mismatched = 0;
    reset = 1'b1;
    mux_in_a = 7'd0; sel_a = 3'd0; mode_a = 1'b0; en_a = 7'd0; hold_a = 1'b0;
    mux_in_b = 128'd0; sel_b = 4'd0; mode_b = 1'b0; en_b = 16'd0; hold_b = 1'b0;
    ma = '{default: 0};
    mb = '{default: 0};
    #2;
    cmp_all();
    #6;
    reset = 1'b0;

    // Manual select latency and out-of-range select
    mux_in_a = 7'b1010101;
    sel_a = 3'd2;
    for (int k = 0; k < 16; k++) mux_in_b[k*8 +: 8] = 8'(k * 17);
    tick();
    check("man.cur", 32'(cur_a), 32'd2);
    check("man.out", 32'(out_a), 32'd1);
    check("man.valid", 32'(valid_a), 32'd1);
    check("man.strobe", 32'(strobe_a), 32'd1);
    tick();
    check("man.strobe_once", 32'(strobe_a), 32'd0);
    sel_a = 3'd7;
    tick();
    check("man.bad_out", 32'(out_a), 32'd0);
    check("man.bad_valid", 32'(valid_a), 32'd0);

    // Scan order and dwell from channel 0
    sel_a = 3'd0;
    tick();
    en_a = 7'b0100101;
    mode_a = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      check("scan.cur", 32'(cur_a), 32'(scan_seq[i]));
      check("scan.strobe", 32'(strobe_a), 32'((i % 4 == 0) && (i > 0)));
    end

    // Forced advance when channel 2 is disabled at dwell count 1
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (cur_a == 3'd2 && strobe_a) found = 1'b1;
    end
    check("force.reach", 32'(found), 32'd1);
    tick();
    en_a = 7'b0100001;
    tick();
    check("force.cur", 32'(cur_a), 32'd5);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("force.restart", 32'(cur_a), (i < 3) ? 32'd5 : 32'd0);
    end

    // Hold in scan while data toggles, then empty mask
    hold_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mux_in_a[0] = ~mux_in_a[0];
      tick();
      check("hold.cur", 32'(cur_a), 32'd0);
      check("hold.out", 32'(out_a), 32'(mux_in_a[0]));
    end
    hold_a = 1'b0;
    en_a = 7'd0;
    tick();
    check("empty.valid", 32'(valid_a), 32'd0);
    check("empty.out", 32'(out_a), 32'd0);
    en_a = 7'b0100000;
    tick();
    check("resume.cur", 32'(cur_a), 32'd5);

    // Asynchronous reset between edges
    #3;
    reset = 1'b1;
    #1;
    check("arst.cur", 32'(cur_a), 32'd0);
    check("arst.out", 32'(out_a), 32'd0);
    check("arst.valid", 32'(valid_a), 32'd0);
    check("arst.strobe", 32'(strobe_a), 32'd0);
    ma = '{default: 0};
    mb = '{default: 0};
    mode_a = 1'b0;
    sel_a = 3'd3;
    #2;
    reset = 1'b0;
    tick();
    check("arst.after", 32'(cur_a), 32'd3);

    // Wide configuration: sel 15 and full-mask wrap with DWELL 1
    sel_b = 4'd15;
    tick();
    check("wide.out", 32'(out_b), 32'hFF);
    en_b = 16'hFFFF;
    mode_b = 1'b1;
    tick();
    check("wide.entry", 32'(cur_b), 32'd15);
    for (int i = 0; i < 18; i++) begin
      tick();
      check("wide.wrap", 32'(cur_b), 32'(i % 16));
    end

    // Randomized traffic against the reference
    for (int i = 0; i < 600; i++) begin
      mux_in_a = 7'($urandom);
      mux_in_b = {$urandom, $urandom, $urandom, $urandom};
      sel_a = 3'($urandom);
      sel_b = 4'($urandom);
      hold_a = ($urandom_range(0, 7) == 0);
      hold_b = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) mode_a = ~mode_a;
      if ($urandom_range(0, 19) == 0) mode_b = ~mode_b;
      if ($urandom_range(0, 9) == 0) en_a = ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom);
      if ($urandom_range(0, 9) == 0) en_b = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
